// File: rtl/demo_counter_checker_if.sv
// Demo counter bus as seen by the checker: the counter's CE/COUNTER plus the
// checker's result signals.
interface demo_counter_checker_if #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned WRAP_CNT_W = 8
);
  logic                  CE;
  logic [WIDTH-1:0]      COUNTER;
  logic                  ERROR;
  logic [ERR_CNT_W-1:0]  ERR_COUNT;
  logic [WIDTH-1:0]      FIRST_EXP;
  logic [WIDTH-1:0]      FIRST_GOT;
  logic [WRAP_CNT_W-1:0] WRAP_COUNT;
  logic                  ERR_PULSE;

  // Counter side: drives CE/COUNTER, may observe the results.
  modport master (
    output CE, COUNTER,
    input  ERROR, ERR_COUNT, FIRST_EXP, FIRST_GOT, WRAP_COUNT, ERR_PULSE
  );

  // Checker side.
  modport slave (
    input  CE, COUNTER,
    output ERROR, ERR_COUNT, FIRST_EXP, FIRST_GOT, WRAP_COUNT, ERR_PULSE
  );
endinterface

// File: rtl/demo_counter_checker.sv
// Consumer-side monitor for the demo counter: shadows the counter, flags every
// cycle where COUNTER did not advance as CE dictated, and keeps error/wrap stats.
module demo_counter_checker #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned ERR_CNT_W  = 8,
  parameter int unsigned WRAP_CNT_W = 8
) (
  input logic CLOCK,
  input logic RESET,
  demo_counter_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } state_t;

  state_t                state, state_d;
  logic [WIDTH-1:0]      prev_cnt, prev_cnt_d;
  logic                  prev_ce, prev_ce_d;
  logic                  error, error_d;
  logic [ERR_CNT_W-1:0]  err_count, err_count_d;
  logic [WIDTH-1:0]      first_exp, first_exp_d;
  logic [WIDTH-1:0]      first_got, first_got_d;
  logic [WRAP_CNT_W-1:0] wrap_count, wrap_count_d;
  logic                  err_pulse, err_pulse_d;

  logic [WIDTH-1:0]      exp_c;
  logic                  mismatch_c;
  logic                  wrap_c;

  // Registers; synchronous reset clears sticky results as well.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= ST_SYNC;
      prev_cnt   <= '0;
      prev_ce    <= 1'b0;
      error      <= 1'b0;
      err_count  <= '0;
      first_exp  <= '0;
      first_got  <= '0;
      wrap_count <= '0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_d;
      prev_cnt   <= prev_cnt_d;
      prev_ce    <= prev_ce_d;
      error      <= error_d;
      err_count  <= err_count_d;
      first_exp  <= first_exp_d;
      first_got  <= first_got_d;
      wrap_count <= wrap_count_d;
      err_pulse  <= err_pulse_d;
    end
  end

  // Next-state and result update.
  always_comb begin
    state_d      = state;
    prev_cnt_d   = bus.COUNTER;
    prev_ce_d    = bus.CE;
    error_d      = error;
    err_count_d  = err_count;
    first_exp_d  = first_exp;
    first_got_d  = first_got;
    wrap_count_d = wrap_count;

    // The first edge after reset expects the counter's reset value.
    exp_c      = (state == ST_SYNC) ? '0 : prev_cnt + WIDTH'(prev_ce);
    mismatch_c = (bus.COUNTER != exp_c);
    wrap_c     = (state != ST_SYNC) && !mismatch_c && prev_ce &&
                 (prev_cnt == '1) && (bus.COUNTER == '0);
    err_pulse_d = mismatch_c;

    case (state)
      ST_SYNC:  state_d = ST_CHECK;
      ST_CHECK: if (mismatch_c) state_d = ST_FAIL;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_SYNC;
    endcase

    if (mismatch_c) begin
      error_d = 1'b1;
      if (err_count != '1) err_count_d = err_count + ERR_CNT_W'(1);
      if (!error) begin
        first_exp_d = exp_c;
        first_got_d = bus.COUNTER;
      end
    end

    if (wrap_c && (wrap_count != '1)) wrap_count_d = wrap_count + WRAP_CNT_W'(1);
  end

  assign bus.ERROR      = error;
  assign bus.ERR_COUNT  = err_count;
  assign bus.FIRST_EXP  = first_exp;
  assign bus.FIRST_GOT  = first_got;
  assign bus.WRAP_COUNT = wrap_count;
  assign bus.ERR_PULSE  = err_pulse;

endmodule

// File: tb/tb_demo_counter_checker.sv
// Directed bench for demo_counter_checker: table of per-cycle vectors plus
// hand-written sequences for long counting, saturation and reset recovery.
module tb_demo_counter_checker;

  localparam int unsigned W = 10;

  typedef struct {
    logic         rst;
    logic         ce;
    logic [W-1:0] cnt;
    logic         e_error;
    logic [7:0]   e_ecnt;
    logic         e_pulse;
    logic [W-1:0] e_fexp;
    logic [W-1:0] e_fgot;
  } vec_t;

  logic CLOCK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  demo_counter_checker_if #(.WIDTH(W), .ERR_CNT_W(8), .WRAP_CNT_W(8)) bus ();
  demo_counter_checker_if #(.WIDTH(W), .ERR_CNT_W(4), .WRAP_CNT_W(8)) bus4 ();

  assign bus4.CE      = bus.CE;
  assign bus4.COUNTER = bus.COUNTER;

  demo_counter_checker #(.WIDTH(W), .ERR_CNT_W(8), .WRAP_CNT_W(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .bus(bus)
  );

  demo_counter_checker #(.WIDTH(W), .ERR_CNT_W(4), .WRAP_CNT_W(8)) dut4 (
    .CLOCK(CLOCK), .RESET(RESET), .bus(bus4)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [W-1:0] v);
    @(negedge CLOCK);
    RESET       = r;
    bus.CE      = c;
    bus.COUNTER = v;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, ".error"},  32'(bus.ERROR),      0);
    chk({tag, ".ecnt"},   32'(bus.ERR_COUNT),  0);
    chk({tag, ".fexp"},   32'(bus.FIRST_EXP),  0);
    chk({tag, ".fgot"},   32'(bus.FIRST_GOT),  0);
    chk({tag, ".wrap"},   32'(bus.WRAP_COUNT), 0);
    chk({tag, ".pulse"},  32'(bus.ERR_PULSE),  0);
  endtask

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic c, input int v,
                              input logic er, input int ec, input logic p,
                              input int fe, input int fg);
    vec_t t;
    t.rst = r; t.ce = c; t.cnt = W'(v);
    t.e_error = er; t.e_ecnt = 8'(ec); t.e_pulse = p;
    t.e_fexp = W'(fe); t.e_fgot = W'(fg);
    return t;
  endfunction

  initial begin
    logic [W-1:0] cnt;
    int pulses;

    RESET = 1'b1; bus.CE = 1'b0; bus.COUNTER = '0;

    // Skip from 5 to 7, later a second glitch that must not move FIRST_*, then reset.
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0, 0));
    for (int k = 0; k <= 5; k++) vecs.push_back(mk(0, 1, k, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 7,   1, 1, 1, 6, 7));
    vecs.push_back(mk(0, 1, 8,   1, 1, 0, 6, 7));
    vecs.push_back(mk(0, 1, 9,   1, 1, 0, 6, 7));
    vecs.push_back(mk(0, 1, 12,  1, 2, 1, 6, 7));
    vecs.push_back(mk(0, 1, 13,  1, 2, 0, 6, 7));
    vecs.push_back(mk(1, 0, 500, 0, 0, 0, 0, 0));
    // CE pattern 1,0,0,1,1,0 correct; then change under CE=0, then hold under CE=1.
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 5,   1, 1, 1, 4, 5));
    vecs.push_back(mk(0, 1, 5,   1, 1, 0, 4, 5));
    vecs.push_back(mk(0, 1, 5,   1, 2, 1, 4, 5));
    // Non-zero value on the first edge after reset.
    vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3,   1, 1, 1, 0, 3));
    vecs.push_back(mk(0, 1, 4,   1, 1, 0, 0, 3));

    // Long reset, then 1100 correct counts with one wrap.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    chk_clear("reset");
    cnt = '0; pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      step(1'b0, 1'b1, cnt);
      if (bus.ERR_PULSE) pulses++;
      cnt = cnt + W'(1);
    end
    chk("long.error", 32'(bus.ERROR), 0);
    chk("long.ecnt",  32'(bus.ERR_COUNT), 0);
    chk("long.wrap",  32'(bus.WRAP_COUNT), 1);
    chk("long.pulses", 32'(pulses), 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ce, vecs[i].cnt);
      chk($sformatf("vec%0d.error", i), 32'(bus.ERROR),     32'(vecs[i].e_error));
      chk($sformatf("vec%0d.ecnt",  i), 32'(bus.ERR_COUNT), 32'(vecs[i].e_ecnt));
      chk($sformatf("vec%0d.pulse", i), 32'(bus.ERR_PULSE), 32'(vecs[i].e_pulse));
      chk($sformatf("vec%0d.fexp",  i), 32'(bus.FIRST_EXP), 32'(vecs[i].e_fexp));
      chk($sformatf("vec%0d.fgot",  i), 32'(bus.FIRST_GOT), 32'(vecs[i].e_fgot));
    end

    // Single-cycle reset pulse from an error state, then 50 correct counts.
    step(1'b1, 1'b0, W'(77));
    chk_clear("rst1");
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, W'(i));
      if (bus.ERR_PULSE) pulses++;
    end
    chk("recover.error",  32'(bus.ERROR), 0);
    chk("recover.pulses", 32'(pulses), 0);

    // 20 consecutive bad cycles: 4-bit counter saturates at 15, 8-bit reaches 20.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, '0);
    chk("sat.pre", 32'(bus4.ERROR), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, W'(100));
      if (bus.ERR_PULSE) pulses++;
    end
    chk("sat.pulses", 32'(pulses), 20);
    chk("sat.ecnt8",  32'(bus.ERR_COUNT), 20);
    chk("sat.ecnt4",  32'(bus4.ERR_COUNT), 15);
    chk("sat.fexp4",  32'(bus4.FIRST_EXP), 1);
    chk("sat.fgot4",  32'(bus4.FIRST_GOT), 100);
    chk("sat.error4", 32'(bus4.ERROR), 1);
    step(1'b0, 1'b1, W'(101));
    chk("sat.match.pulse", 32'(bus4.ERR_PULSE), 0);
    chk("sat.match.ecnt4", 32'(bus4.ERR_COUNT), 15);
    step(1'b0, 1'b1, W'(50));
    chk("sat.hold.pulse", 32'(bus4.ERR_PULSE), 1);
    chk("sat.hold.ecnt4", 32'(bus4.ERR_COUNT), 15);
    chk("sat.hold.ecnt8", 32'(bus.ERR_COUNT), 21);
    chk("sat.hold.fgot4", 32'(bus4.FIRST_GOT), 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
